// File: rtl/rr_arbiter_buffered_if.sv
// Handshake bundle for rr_arbiter_buffered: SIZE packed producers in, one buffered token out.
// slave is the arbiter's view; master is the producer/consumer side.
interface rr_arbiter_buffered_if #(
  parameter int SIZE        = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 1
);
  logic [SIZE*DATA_WIDTH-1:0] ins;
  logic [SIZE-1:0]            ins_valid;
  logic [SIZE-1:0]            ins_ready;
  logic [DATA_WIDTH-1:0]      outs;
  logic [INDEX_WIDTH-1:0]     index;
  logic                       outs_valid;
  logic                       outs_ready;

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, index, outs_valid
  );

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, index, outs_valid
  );
endinterface

// File: rtl/rr_arbiter_buffered.sv
// Round-robin arbiter into a one-slot output register: 1-cycle latency, 1 token/cycle; ins_ready
// drops while the slot is full and outs_ready is low. RR_ARBITER_STALL_CNT_EN adds a stall counter.
module rr_arbiter_buffered #(
  parameter int SIZE        = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter_buffered_if.slave bus
`ifdef RR_ARBITER_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic [DATA_WIDTH-1:0]  outs_q, outs_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   outs_valid_q, outs_valid_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

  logic                   found;
  logic [INDEX_WIDTH-1:0] win;
  logic                   grant;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic [SIZE-1:0]        ins_ready_c;

  // Two passes give the circular scan: first from ptr upward, then wrap from 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (!found && bus.ins_valid[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        win   = i[INDEX_WIDTH-1:0];
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      if (!found && bus.ins_valid[i]) begin
        found = 1'b1;
        win   = i[INDEX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant       = rst && found && (!outs_valid_q || bus.outs_ready);
    ins_ready_c = '0;
    sel_dat     = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (int'(win) == i) begin
        ins_ready_c[i] = grant;
        sel_dat        = bus.ins[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    outs_d       = outs_q;
    index_d      = index_q;
    outs_valid_d = outs_valid_q;
    ptr_d        = ptr_q;
    if (grant) begin
      outs_d       = sel_dat;
      index_d      = win;
      outs_valid_d = 1'b1;
      ptr_d        = (int'(win) == SIZE - 1) ? '0 : win + INDEX_WIDTH'(1);
    end else if (bus.outs_ready) begin
      outs_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outs_q       <= '0;
      index_q      <= '0;
      outs_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      index_q      <= index_d;
      outs_valid_q <= outs_valid_d;
      ptr_q        <= ptr_d;
    end
  end

`ifdef RR_ARBITER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (outs_valid_q && !bus.outs_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.ins_ready  = ins_ready_c;
  assign bus.outs       = outs_q;
  assign bus.index      = index_q;
  assign bus.outs_valid = outs_valid_q;

endmodule

// File: tb/tb_rr_arbiter_buffered.sv
// Directed bench for rr_arbiter_buffered with SIZE=4; stall_cnt is checked when the macro is defined.
module tb_rr_arbiter_buffered;
  localparam int SIZE = 4;
  localparam int DW   = 32;
  localparam int IW   = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter_buffered_if #(.SIZE(SIZE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus_if ();

`ifdef RR_ARBITER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  rr_arbiter_buffered #(.SIZE(SIZE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave)
`ifdef RR_ARBITER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_payloads();
    for (int i = 0; i < SIZE; i++) bus_if.ins[i*DW +: DW] = 32'hA0 + i;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst                  = 1'b0;
    bus_if.ins_valid     = 4'b0011;
    bus_if.outs_ready    = 1'b1;
    set_default_payloads();
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_pre: got %b expected 0000", bus_if.ins_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus_if.outs_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", c, bus_if.outs_valid);
      end
      checks++;
      if (bus_if.ins_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b expected 0000", c, bus_if.ins_ready);
      end
      checks++;
      if (bus_if.index !== 2'd0) begin
        errors++; $display("FAIL reset_index[%0d]: got %0d expected 0", c, bus_if.index);
      end
      checks++;
      if (bus_if.outs !== 32'h0) begin
        errors++; $display("FAIL reset_outs[%0d]: got %h expected 0", c, bus_if.outs);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 0001", bus_if.ins_ready);
    end
    tick();
    checks++;
    if (bus_if.outs_valid !== 1'b1 || bus_if.index !== 2'd0 || bus_if.outs !== 32'hA0) begin
      errors++;
      $display("FAIL reset_first_token: got v=%b idx=%0d outs=%h expected v=1 idx=0 outs=a0",
               bus_if.outs_valid, bus_if.index, bus_if.outs);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_out [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    set_default_payloads();
    bus_if.ins_valid  = 4'b1111;
    bus_if.outs_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus_if.ins_ready !== exp_rdy[k]) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus_if.ins_ready, exp_rdy[k]);
      end
      tick();
      checks++;
      if (bus_if.outs_valid !== 1'b1 || bus_if.index !== exp_idx[k] || bus_if.outs !== exp_out[k]) begin
        errors++;
        $display("FAIL rr_token[%0d]: got v=%b idx=%0d outs=%h expected v=1 idx=%0d outs=%h",
                 k, bus_if.outs_valid, bus_if.index, bus_if.outs, exp_idx[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_default_payloads();
    bus_if.ins_valid  = 4'b1111;
    bus_if.outs_ready = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus_if.ins_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, bus_if.ins_ready);
      end
      checks++;
      if (bus_if.outs_valid !== 1'b1 || bus_if.index !== 2'd0 || bus_if.outs !== 32'hA0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b idx=%0d outs=%h expected v=1 idx=0 outs=a0",
                 k, bus_if.outs_valid, bus_if.index, bus_if.outs);
      end
      tick();
    end
`ifdef RR_ARBITER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++; $display("FAIL bp_stall_cnt: got %0d expected 5", stall_cnt);
    end
`endif
    bus_if.outs_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_resume_ready: got %b expected 0010", bus_if.ins_ready);
    end
    tick();
    checks++;
    if (bus_if.outs_valid !== 1'b1 || bus_if.index !== 2'd1 || bus_if.outs !== 32'hA1) begin
      errors++;
      $display("FAIL bp_resume_token: got v=%b idx=%0d outs=%h expected v=1 idx=1 outs=a1",
               bus_if.outs_valid, bus_if.index, bus_if.outs);
    end
`ifdef RR_ARBITER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++; $display("FAIL bp_stall_hold: got %0d expected 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_sparse();
    logic [3:0] vld_seq [5] = '{4'b0010, 4'b0010, 4'b1111, 4'b1001, 4'b0011};
    logic [3:0] rdy_seq [5] = '{4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] idx_seq [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    set_default_payloads();
    bus_if.ins_valid  = 4'b0000;
    bus_if.outs_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus_if.ins_valid = vld_seq[k];
      #1;
      checks++;
      if (bus_if.ins_ready !== rdy_seq[k]) begin
        errors++; $display("FAIL sparse_ready[%0d]: got %b expected %b", k, bus_if.ins_ready, rdy_seq[k]);
      end
      tick();
      checks++;
      if (bus_if.outs_valid !== 1'b1 || bus_if.index !== idx_seq[k]) begin
        errors++;
        $display("FAIL sparse_token[%0d]: got v=%b idx=%0d expected v=1 idx=%0d",
                 k, bus_if.outs_valid, bus_if.index, idx_seq[k]);
      end
      if (k == 0) begin
        bus_if.ins_valid = 4'b0000;
        #1;
        checks++;
        if (bus_if.ins_ready !== 4'b0000) begin
          errors++; $display("FAIL sparse_idle_ready: got %b expected 0000", bus_if.ins_ready);
        end
        tick();
        checks++;
        if (bus_if.outs_valid !== 1'b0 || bus_if.index !== 2'd1 || bus_if.outs !== 32'hA1) begin
          errors++;
          $display("FAIL sparse_drain: got v=%b idx=%0d outs=%h expected v=0 idx=1 outs=a1",
                   bus_if.outs_valid, bus_if.index, bus_if.outs);
        end
      end
    end
  endtask

  task automatic test_drain_fill();
    set_default_payloads();
    bus_if.ins[0 +: DW] = 32'h11;
    bus_if.ins_valid    = 4'b0001;
    bus_if.outs_ready   = 1'b0;
    do_reset();
    tick();
    checks++;
    if (bus_if.outs_valid !== 1'b1 || bus_if.outs !== 32'h11) begin
      errors++; $display("FAIL df_first: got v=%b outs=%h expected v=1 outs=11", bus_if.outs_valid, bus_if.outs);
    end
    bus_if.ins[0 +: DW] = 32'h22;
    bus_if.outs_ready   = 1'b1;
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0001) begin
      errors++; $display("FAIL df_ready: got %b expected 0001", bus_if.ins_ready);
    end
    tick();
    checks++;
    if (bus_if.outs_valid !== 1'b1 || bus_if.outs !== 32'h22 || bus_if.index !== 2'd0) begin
      errors++;
      $display("FAIL df_replace: got v=%b idx=%0d outs=%h expected v=1 idx=0 outs=22",
               bus_if.outs_valid, bus_if.index, bus_if.outs);
    end
    set_default_payloads();
  endtask

  task automatic test_reset_mid();
    set_default_payloads();
    bus_if.ins_valid  = 4'b1111;
    bus_if.outs_ready = 1'b0;
    do_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_ready: got %b expected 0000", bus_if.ins_ready);
    end
    tick();
    checks++;
    if (bus_if.outs_valid !== 1'b0 || bus_if.outs !== 32'h0 || bus_if.index !== 2'd0) begin
      errors++;
      $display("FAIL rmid_state: got v=%b idx=%0d outs=%h expected v=0 idx=0 outs=0",
               bus_if.outs_valid, bus_if.index, bus_if.outs);
    end
`ifdef RR_ARBITER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rmid_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    rst = 1'b1;
    bus_if.outs_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.ins_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_ptr: got %b expected 0001", bus_if.ins_ready);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b0;
    bus_if.ins        = '0;
    bus_if.ins_valid  = '0;
    bus_if.outs_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_drain_fill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_buffered.md
Name: rr_arbiter_buffered

Overview:
- Shares one downstream dataflow channel among SIZE upstream producers using round-robin arbitration.
- Latches the winning token plus its source index into a one-slot output register. Latency is 1 cycle and throughput is 1 token/cycle.
- Sits upstream of join/merge-style consumers in the handshake library.
- Provides a fair, registered alternative to the combinational control-merge.

Parameters:
- SIZE, 2, number of requesting inputs; legal range 2..16.
- DATA_WIDTH, 32, token payload width in bits.
- INDEX_WIDTH, 1, width of the winner index; must be at least ceil(log2(SIZE)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- ins  input  SIZE*DATA_WIDTH  packed payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ins_valid  input  SIZE  per-input valid.
- ins_ready  output  SIZE  per-input ready; one-hot or zero.
- outs  output  DATA_WIDTH  registered payload of the buffered token.
- index  output  INDEX_WIDTH  registered source index of the buffered token.
- outs_valid  output  1  output slot full.
- outs_ready  input  1  downstream accepts the token.

Behaviour:
- Reset (rst=0 at a clk edge):
  - outs_valid=0, outs=0, index=0.
  - Priority pointer ptr=0, so input 0 has highest priority.
  - ins_ready=0 combinationally while rst=0.
- Slot state: EMPTY when outs_valid=0, FULL when outs_valid=1. There is no other FSM state besides ptr.
- can_accept = !outs_valid | outs_ready.
- Grant (combinational):
  - The winner w is the first i with ins_valid[i]=1, scanning ptr, ptr+1, … SIZE-1, 0, … ptr-1 (modulo SIZE).
  - ins_ready = one-hot(w) if can_accept and any ins_valid; otherwise 0.
  - ins_ready never depends on ins_valid of the same input alone. It is only asserted toward a valid input.
- Transfer in: when ins_valid[w] & ins_ready[w] at an edge:
  - outs <= ins[w], index <= w, outs_valid <= 1.
  - ptr <= (w+1) mod SIZE; when w = SIZE-1, ptr wraps to 0.
- Transfer out: when outs_valid & outs_ready and no new grant, outs_valid <= 0. outs and index hold their last value.
- Simultaneous in/out on a FULL slot with outs_ready=1 and a winner present: the new token replaces the old one in the same cycle, with no bubble. outs_valid stays 1.
- No requests: ptr unchanged; the slot drains normally.
- Stable output:
  - While outs_valid=1 & outs_ready=0, outs, index and outs_valid hold.
  - ins_ready=0 in that state.
- Fairness: a continuously valid input is granted within SIZE accepted transfers.
- Reset mid-operation: a buffered token is discarded, outs_valid=0 on the next cycle and ptr=0. Upstream tokens are not consumed during reset.
- Combinational paths:
  - outs_ready -> ins_ready exists.
  - ins_valid -> ins_ready exists.
  - No path from ins to outs without a register.

Optional Feature:
- Macro: RR_ARBITER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Counts cycles with outs_valid=1 & outs_ready=0, saturating at 16'hFFFF.
  - Cleared to 0 by reset. Updated on the same edge as the other state.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with ins_valid=2'b11 -> outs_valid=0, ins_ready=0, index=0. After release, the first grant goes to input 0.
- Full-rate round-robin: SIZE=4, all valid, outs_ready=1 constantly, ins[i]=32'hA0+i -> one token per cycle; index sequence 0,1,2,3,0; outs sequence A0,A1,A2,A3,A0.
- Backpressure: token buffered, then outs_ready=0 for 5 cycles -> outs and index stable, ins_ready=0 for those cycles. With the macro defined, stall_cnt=5. Then outs_ready=1 -> the next grant resumes from ptr.
- Sparse requests: SIZE=4, ptr=2, only ins_valid[1]=1 -> wrap-around grant to input 1, index=1, ptr becomes 2.
- Simultaneous drain and fill: FULL slot holding 32'h11, outs_ready=1, ins_valid[0]=1 with payload 32'h22 -> next cycle outs=32'h22, outs_valid=1, no empty cycle between tokens.
- Reset mid-stream: rst=0 while outs_valid=1 -> next cycle outs_valid=0 and ptr=0. With the macro defined, stall_cnt=0.
